// File: rtl/rr_sched_8ch.sv
// rr_sched_8ch: 8-channel round-robin burst scheduler with registered output; define RR_SCHED_PRIO0_EN to give channel 0 strict priority
module rr_sched_8ch #(
  parameter int NUM_CH    = 8,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic [NUM_CH-1:0]        in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [2:0]               out_ch,
  input  logic                     out_ready
);
  typedef enum logic {ARB, GRANT} state_t;
  state_t            state;
  logic [2:0]        grant, rr_ptr, pick;
  logic [3:0]        burst_cnt;
  logic [DATA_W-1:0] ch_data [NUM_CH];
  logic              can_load, accept, last_beat, done, move_ptr;
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) ch_data[i] = in_data[i*DATA_W +: DATA_W];
  end
  // descending scan so the nearest requester after rr_ptr wins
  always_comb begin
    pick = rr_ptr;
    for (int i = NUM_CH; i >= 1; i--) if (in_valid[rr_ptr + 3'(i)]) pick = rr_ptr + 3'(i);
`ifdef RR_SCHED_PRIO0_EN
    if (in_valid[0]) pick = '0;
`endif
  end
`ifdef RR_SCHED_PRIO0_EN
  assign move_ptr = grant != 3'd0;
`else
  assign move_ptr = 1'b1;
`endif
  assign can_load  = !out_valid || out_ready;
  assign accept    = state == GRANT && in_valid[grant] && can_load;
  assign last_beat = burst_cnt == 4'(MAX_BURST - 1);
  assign done      = (accept && last_beat) || (can_load && !in_valid[grant]);
  always_comb begin
    in_ready        = '0;
    in_ready[grant] = accept;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ARB;
      grant     <= '0;
      burst_cnt <= '0;
      rr_ptr    <= 3'(NUM_CH - 1);
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        out_data  <= ch_data[grant];
        out_ch    <= grant;
        burst_cnt <= burst_cnt + 4'd1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (state == ARB) begin
        if (|in_valid) begin
          state     <= GRANT;
          grant     <= pick;
          burst_cnt <= '0;
        end
      end else if (done) begin
        state <= ARB;
        if (move_ptr) rr_ptr <= grant;
      end
    end
  end
endmodule

// File: doc/rr_sched_8ch.md
# rr_sched_8ch

Round-robin scheduler that shares the single output channel among eight input channels. Each input channel offers data beats with a valid/ready handshake. The block grants one channel at a time for a bounded burst and forwards accepted beats through a registered output stage tagged with the source channel ID. It is the arbitration core instantiated inside the top-level interface wrapper between the eight input interfaces and the output interface.

## Interface
- NUM_CH, 8, number of input channels (fixed at 8 for this release; ID width 3)
- DATA_W, 32, beat data width
- MAX_BURST, 4, maximum beats per grant before rotation (1..15)

- clk  input  1  single clock, all state on rising edge
- reset_n  input  1  asynchronous active-low reset
- in_valid  input  NUM_CH  per-channel beat valid
- in_data  input  NUM_CH*DATA_W  per-channel beat data, channel i at bits [i*DATA_W +: DATA_W]
- in_ready  output  NUM_CH  per-channel accept; at most one bit set
- out_valid  output  1  output beat valid
- out_data  output  DATA_W  output beat data
- out_ch  output  3  source channel of output beat
- out_ready  input  1  downstream accept

## Operation
- Two-state FSM: ARB and GRANT. Reset state is ARB.
- ARB: if any in_valid is set, select the first requesting channel strictly after rr_ptr, searching upward mod 8. Register it as grant, clear burst_cnt, and go to GRANT. If no channel requests, stay in ARB.
- GRANT: in_ready[grant] = in_valid[grant] && (!out_valid || out_ready). All other in_ready bits are 0. In ARB, all in_ready bits are 0.
- Beat accepted (in_valid[grant] && in_ready[grant]): load out_data = in_data[grant], out_ch = grant, out_valid = 1, and increment burst_cnt.
- GRANT exits to ARB and sets rr_ptr = grant when either:
  - burst_cnt reaches MAX_BURST (counting the beat accepted this cycle), or
  - in_valid[grant] is 0 in a cycle where the output stage could accept (!out_valid || out_ready).
- A stalled output (out_valid && !out_ready) holds grant and burst_cnt indefinitely. Burst exit is never taken because of output backpressure.
- Output register: out_valid clears when out_ready is high and no new beat is loaded in the same cycle. Data and ch stay stable while out_valid && !out_ready.
- Channel order is preserved: beats from one channel leave in acceptance order. No beat is dropped or duplicated.

## Timing
- Reset values: out_valid 0, out_data 0, out_ch 0, in_ready 0, grant 0, burst_cnt 0, rr_ptr 7 (so channel 0 wins first).
- Arbitration costs one cycle. A request seen in ARB at cycle N gives in_ready at cycle N+1.
- Beat accepted at edge N appears on out_valid/out_data after edge N, i.e. 1-cycle latency.
- Sustained throughput with out_ready=1 and all channels busy: MAX_BURST beats per MAX_BURST+1 cycles.
- The simultaneous out_ready handshake and new load in one cycle is supported, giving full rate inside a burst.
- A channel dropping in_valid mid-burst ends its grant with no beat lost. It re-requests through normal rotation.
- Asserting reset_n low mid-burst clears all state immediately. A beat held in the output register is discarded.
- burst_cnt is 4 bits and never wraps, because the exit at MAX_BURST occurs first.

## Configuration
- RR_SCHED_PRIO0_EN defined: in ARB, channel 0 wins whenever in_valid[0] is set, regardless of rr_ptr. rr_ptr is not updated when channel 0's grant ends, so the other channels keep their rotation.
- Undefined: pure round-robin as above, with channel 0 treated like the others.

## Test plan
- Reset then single channel: ch3 offers 10 beats 0x30..0x39, out_ready=1. Output shows bursts of 4,4,2 (one idle cycle between bursts), out_ch=3, data in order.
- Fairness: all 8 channels hold valid with 8 beats each. Grant order is 0,1,...,7,0,...,7. Each grant delivers exactly 4 beats, and the total is 64 beats.
- Backpressure: ch1 streaming, out_ready toggles 1,0,0,1. out_data/out_ch stay stable while stalled, in_ready[1]=0 while out_valid && !out_ready, and no loss.
- Early release: ch5 sends 2 beats then drops valid, ch6 waiting. Grant moves to 6 after the ARB cycle, and rr_ptr=5.
- Reset mid-burst: reset_n low while out_valid=1 with ch2 granted. All outputs return to reset values that cycle, and after release ch0 is arbitrated first.
- With RR_SCHED_PRIO0_EN: ch0 and ch4 both request continuously. ch0 receives every grant and ch4 is starved. After ch0 drops valid, ch4 is granted next.
